bch3d_128_dec_arb: RTL and testbench
====================================

# bch3d_128_dec_arb

Arbiter and sequencer that shares one BCH 128/145 decoder between a host read path and a background memory scrubber. It accepts 145-bit codewords from two requesters, issues them to the decoder one per cycle, tracks which requester owns each in-flight word across the decoder latency, and routes the 128-bit data plus error class back to the owner. It sits between the memory read port/scrub engine and the decoder instance, and keeps saturating error statistics.

## Interface
Parameters:
- `DEC_LAT`, 1: cycles from `dec_en` high to the matching `dec_valid` (≥1).
- `STARVE_LIM`, 8: scrubber wait cycles before it gets priority (1..255).
- `CNT_W`, 16: error counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `h_req`  in  1  host request; `h_code` held stable until granted.
- `h_code`  in  145  host codeword.
- `h_gnt`  out  1  host grant (combinational); transfer when `h_req && h_gnt`.
- `h_rsp_valid`  out  1  host response strobe, 1 cycle.
- `h_rsp_data`  out  128  host decoded data.
- `h_rsp_err`  out  2  host error class.
- `s_req`, `s_code`, `s_gnt`, `s_rsp_valid`, `s_rsp_data`, `s_rsp_err`: scrubber, same widths and rules.
- `dec_en`  out  1  decoder enable, 1-cycle pulse per issued word.
- `dec_code`  out  145  codeword to decoder.
- `dec_data`  in  128  decoder data.
- `dec_valid`  in  1  decoder output valid.
- `dec_err_corr`, `dec_err_detec`, `dec_err_fatal`  in  1 each  decoder flags.
- `corr_cnt`  out  CNT_W  corrected-word count.
- `fatal_cnt`  out  CNT_W  uncorrectable-word count.
- `cnt_clr`  in  1  synchronous counter clear.
- `proto_err`  out  1  sticky decoder protocol error.

## Operation
- Arbitration: host has priority. `wait_cnt` (8 bit) increments each cycle `s_req && !s_gnt`; cleared on scrubber grant or `!s_req`. `s_prio = (wait_cnt == STARVE_LIM)`.
- `h_gnt = h_req && !(s_prio && s_req)`; `s_gnt = s_req && (!h_req || s_prio)`. At most one grant per cycle.
- On grant: `dec_code <=` granted code, `dec_en <= 1` next cycle; tag bit (0 host, 1 scrubber) plus valid enters a shift pipeline of depth `DEC_LAT`. No grant: `dec_en <= 0`, `dec_code` holds.
- On `dec_valid`: pipeline tail must be valid; response routed to the tagged requester. Tail valid without `dec_valid`, or `dec_valid` with empty tail: set `proto_err` (sticky until reset), drop the word, no response.
- Error class, priority order: `dec_err_fatal` → 2'b11; else `dec_err_detec && !dec_err_corr` → 2'b10; else `dec_err_corr` → 2'b01; else 2'b00.
- Counters: class 01 increments `corr_cnt`; 10 or 11 increments `fatal_cnt`; saturate at all-ones. `cnt_clr` wins over a same-cycle increment.

## Timing
- Grant cycle N → `dec_en` at N+1 → `dec_valid` at N+1+DEC_LAT → `*_rsp_valid` registered at N+2+DEC_LAT. Throughput one word/cycle.
- Counters update in the same cycle as `*_rsp_valid`.
- Reset values: all outputs 0, `wait_cnt` 0, pipeline empty, counters 0, `proto_err` 0.
- Reset mid-operation: in-flight words are discarded, no responses. `proto_err` detection is masked for `DEC_LAT+1` cycles after reset deasserts.
- Grants are combinational from `req` and registered state only, with no path from `dec_*` inputs.

## Configuration
- `BCH_ARB_ERR_CNT_EN`: when defined, `corr_cnt`/`fatal_cnt` logic is built as specified. When undefined, the ports remain, are tied to 0, `cnt_clr` is ignored, and no counter flops are built.

## Test plan
- Host only, `h_code=0` for 1 cycle, DEC_LAT=1, decoder returns clean → `h_gnt` at N, `dec_en` at N+1, `h_rsp_valid` at N+3 with `h_rsp_err=00`. `corr_cnt=0`.
- Host and scrubber both requesting continuously, STARVE_LIM=8 → host granted 8 cycles, scrubber granted on cycle 9, `wait_cnt` returns to 0, host regains grant. Repeat with `proto_err=0`.
- Back-to-back 4 words alternating owners, decoder flags corr/fatal/detec/clean → responses in issue order to correct owners with classes 01/11/10/00. `corr_cnt=1`, `fatal_cnt=2`.
- CNT_W=2, 5 corrected words, then `cnt_clr` coincident with a sixth → `corr_cnt` saturates at 3, then reads 0.
- Inject `dec_valid` with empty pipeline → `proto_err=1` sticky, no response. Assert `reset` with 2 words in flight → no responses, `proto_err=0`.
- Build without `BCH_ARB_ERR_CNT_EN`, corrected words → counters stay 0, responses unchanged.

Source files
------------

// File: rtl/bch3d_128_dec_arb_if.sv
// Bus bundle between the BCH decoder arbiter and its neighbours: host read
// path, scrub engine, decoder instance and the statistics/status signals.
//   slave  : arbiter side (takes requests and decoder results, drives grants,
//            responses, decoder issue, counters and proto_err)
//   master : environment side (the opposite directions)
// CNT_W sets the width of corr_cnt/fatal_cnt and must match the arbiter.
interface bch3d_128_dec_arb_if #(
    parameter int unsigned CNT_W = 16
);
    // host requester
    logic         h_req;
    logic [144:0] h_code;
    logic         h_gnt;
    logic         h_rsp_valid;
    logic [127:0] h_rsp_data;
    logic [1:0]   h_rsp_err;
    // scrub requester
    logic         s_req;
    logic [144:0] s_code;
    logic         s_gnt;
    logic         s_rsp_valid;
    logic [127:0] s_rsp_data;
    logic [1:0]   s_rsp_err;
    // decoder
    logic         dec_en;
    logic [144:0] dec_code;
    logic [127:0] dec_data;
    logic         dec_valid;
    logic         dec_err_corr;
    logic         dec_err_detec;
    logic         dec_err_fatal;
    // statistics / status
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] fatal_cnt;
    logic             cnt_clr;
    logic             proto_err;

    modport slave (
        input  h_req, h_code, s_req, s_code,
        input  dec_data, dec_valid, dec_err_corr, dec_err_detec, dec_err_fatal,
        input  cnt_clr,
        output h_gnt, h_rsp_valid, h_rsp_data, h_rsp_err,
        output s_gnt, s_rsp_valid, s_rsp_data, s_rsp_err,
        output dec_en, dec_code, corr_cnt, fatal_cnt, proto_err
    );

    modport master (
        output h_req, h_code, s_req, s_code,
        output dec_data, dec_valid, dec_err_corr, dec_err_detec, dec_err_fatal,
        output cnt_clr,
        input  h_gnt, h_rsp_valid, h_rsp_data, h_rsp_err,
        input  s_gnt, s_rsp_valid, s_rsp_data, s_rsp_err,
        input  dec_en, dec_code, corr_cnt, fatal_cnt, proto_err
    );
endinterface

// File: rtl/bch3d_128_dec_arb.sv
// Shares one BCH 128/145 decoder between the host read path and the scrubber.
// Arbitrates one codeword per cycle (host priority, scrubber anti-starvation),
// tracks the owner of each in-flight word across DEC_LAT cycles, routes the
// decoded data and error class back to the owner and keeps error statistics.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    bch3d_128_dec_arb_if.slave (requests, grants, responses, decoder
//          issue/return, counters, cnt_clr, proto_err)
// Build option: define BCH_ARB_ERR_CNT_EN to build corr_cnt/fatal_cnt; when
// undefined the counters read 0 and cnt_clr is ignored.
module bch3d_128_dec_arb #(
    parameter int unsigned DEC_LAT    = 1,
    parameter int unsigned STARVE_LIM = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    bch3d_128_dec_arb_if.slave     bus
);
    localparam int unsigned WAIT_W = 8;
    localparam int unsigned MASK_W = $clog2(DEC_LAT + 2);

    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               w_s_prio;
    logic               w_h_gnt;
    logic               w_s_gnt;
    logic               r_dec_en;
    logic               r_dec_tag;
    logic [144:0]       r_dec_code;
    logic [DEC_LAT-1:0] r_pipe_v;
    logic [DEC_LAT-1:0] r_pipe_tag;
    logic               w_tail_v;
    logic               w_tail_tag;
    logic               w_fire;
    logic [1:0]         w_err;
    logic [MASK_W-1:0]  r_mask_cnt;
    logic               r_proto_err;
    logic               r_h_rsp_valid;
    logic [127:0]       r_h_rsp_data;
    logic [1:0]         r_h_rsp_err;
    logic               r_s_rsp_valid;
    logic [127:0]       r_s_rsp_data;
    logic [1:0]         r_s_rsp_err;

    // Grants depend only on requests and r_wait_cnt.
    assign w_s_prio = (r_wait_cnt == WAIT_W'(STARVE_LIM));
    assign w_h_gnt  = bus.h_req && !(w_s_prio && bus.s_req);
    assign w_s_gnt  = bus.s_req && (!bus.h_req || w_s_prio);

    // Scrubber starvation counter; never passes STARVE_LIM since reaching it forces a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (!bus.s_req || w_s_gnt) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
    end

    // Decoder issue register; owner tag travels alongside dec_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dec_en   <= 1'b0;
            r_dec_tag  <= 1'b0;
            r_dec_code <= '0;
        end else begin
            r_dec_en <= w_h_gnt || w_s_gnt;
            if (w_s_gnt) begin
                r_dec_code <= bus.s_code;
                r_dec_tag  <= 1'b1;
            end else if (w_h_gnt) begin
                r_dec_code <= bus.h_code;
                r_dec_tag  <= 1'b0;
            end
        end
    end

    // Owner pipeline fed from the issue stage so its tail lines up with dec_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_v   <= '0;
            r_pipe_tag <= '0;
        end else begin
            r_pipe_v[0]   <= r_dec_en;
            r_pipe_tag[0] <= r_dec_tag;
            for (int i = 1; i < int'(DEC_LAT); i++) begin
                r_pipe_v[i]   <= r_pipe_v[i-1];
                r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
        end
    end

    assign w_tail_v   = r_pipe_v[DEC_LAT-1];
    assign w_tail_tag = r_pipe_tag[DEC_LAT-1];
    assign w_fire     = bus.dec_valid && w_tail_v;

    // Error class, most severe first.
    always_comb begin
        w_err = 2'b00;
        if (bus.dec_err_fatal) begin
            w_err = 2'b11;
        end else if (bus.dec_err_detec && !bus.dec_err_corr) begin
            w_err = 2'b10;
        end else if (bus.dec_err_corr) begin
            w_err = 2'b01;
        end
    end

    // Protocol check; masked while the decoder may still flush pre-reset words.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask_cnt  <= MASK_W'(DEC_LAT + 1);
            r_proto_err <= 1'b0;
        end else begin
            if (r_mask_cnt != '0) begin
                r_mask_cnt <= r_mask_cnt - MASK_W'(1);
            end
            if ((bus.dec_valid != w_tail_v) && (r_mask_cnt == '0)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // Response routing to the tagged owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_rsp_valid <= 1'b0;
            r_h_rsp_data  <= '0;
            r_h_rsp_err   <= 2'b00;
            r_s_rsp_valid <= 1'b0;
            r_s_rsp_data  <= '0;
            r_s_rsp_err   <= 2'b00;
        end else begin
            r_h_rsp_valid <= w_fire && !w_tail_tag;
            r_s_rsp_valid <= w_fire && w_tail_tag;
            if (w_fire && !w_tail_tag) begin
                r_h_rsp_data <= bus.dec_data;
                r_h_rsp_err  <= w_err;
            end
            if (w_fire && w_tail_tag) begin
                r_s_rsp_data <= bus.dec_data;
                r_s_rsp_err  <= w_err;
            end
        end
    end

`ifdef BCH_ARB_ERR_CNT_EN
    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_fatal_cnt;

    // Saturating statistics; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || bus.cnt_clr) begin
            r_corr_cnt  <= '0;
            r_fatal_cnt <= '0;
        end else if (w_fire) begin
            if ((w_err == 2'b01) && (r_corr_cnt != '1)) begin
                r_corr_cnt <= r_corr_cnt + CNT_W'(1);
            end
            if (w_err[1] && (r_fatal_cnt != '1)) begin
                r_fatal_cnt <= r_fatal_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.corr_cnt  = r_corr_cnt;
    assign bus.fatal_cnt = r_fatal_cnt;
`else
    logic w_unused_ok;
    assign w_unused_ok   = bus.cnt_clr;
    assign bus.corr_cnt  = '0;
    assign bus.fatal_cnt = '0;
`endif

    assign bus.h_gnt       = w_h_gnt;
    assign bus.s_gnt       = w_s_gnt;
    assign bus.dec_en      = r_dec_en;
    assign bus.dec_code    = r_dec_code;
    assign bus.h_rsp_valid = r_h_rsp_valid;
    assign bus.h_rsp_data  = r_h_rsp_data;
    assign bus.h_rsp_err   = r_h_rsp_err;
    assign bus.s_rsp_valid = r_s_rsp_valid;
    assign bus.s_rsp_data  = r_s_rsp_data;
    assign bus.s_rsp_err   = r_s_rsp_err;
    assign bus.proto_err   = r_proto_err;
endmodule

// File: tb/tb_bch3d_128_dec_arb.sv
// Directed bench for bch3d_128_dec_arb (DEC_LAT=1, STARVE_LIM=8, CNT_W=2).
// The bench plays the decoder: one cycle after dec_en it returns
// dec_code[127:0] ^ DMASK with flags taken from dec_code[144:142]
// (fatal, detec, corr). inj forces a stray dec_valid.
module tb_bch3d_128_dec_arb;
    localparam logic [127:0] DMASK = {4{32'hA5A5_5A5A}};
`ifdef BCH_ARB_ERR_CNT_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic inj;
    int   errors = 0;
    int   checks = 0;

    bch3d_128_dec_arb_if #(.CNT_W(2)) bus ();

    bch3d_128_dec_arb #(.DEC_LAT(1), .STARVE_LIM(8), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Decoder model, latency 1.
    always @(posedge clk) begin
        bus.dec_valid     <= bus.dec_en | inj;
        bus.dec_data      <= bus.dec_code[127:0] ^ DMASK;
        bus.dec_err_fatal <= bus.dec_en & bus.dec_code[144];
        bus.dec_err_detec <= bus.dec_en & bus.dec_code[143];
        bus.dec_err_corr  <= bus.dec_en & bus.dec_code[142];
    end

    function automatic logic [144:0] mk(input logic [2:0] fl, input logic [127:0] d);
        return {fl, 14'd0, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [144:0] got, input logic [144:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    logic [144:0] ca, cb, cc, cd;

    initial begin
        reset = 1'b1;
        inj   = 1'b0;
        bus.h_req = 1'b0; bus.h_code = '0;
        bus.s_req = 1'b0; bus.s_code = '0;
        bus.cnt_clr = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_h_gnt",     145'(bus.h_gnt), 145'(0));
        chk("rst_dec_en",    145'(bus.dec_en), 145'(0));
        chk("rst_h_rsp_v",   145'(bus.h_rsp_valid), 145'(0));
        chk("rst_s_rsp_v",   145'(bus.s_rsp_valid), 145'(0));
        chk("rst_proto",     145'(bus.proto_err), 145'(0));
        chk("rst_corr",      145'(bus.corr_cnt), 145'(0));
        chk("rst_fatal",     145'(bus.fatal_cnt), 145'(0));
        reset = 1'b0;
        repeat (4) tick();

        // single host word, clean decode
        bus.h_req = 1'b1; bus.h_code = '0;
        #1;
        chk("t1_h_gnt", 145'(bus.h_gnt), 145'(1));
        chk("t1_s_gnt", 145'(bus.s_gnt), 145'(0));
        tick(); bus.h_req = 1'b0;
        chk("t1_dec_en",   145'(bus.dec_en), 145'(1));
        chk("t1_dec_code", bus.dec_code, 145'(0));
        tick();
        chk("t1_rsp_early", 145'(bus.h_rsp_valid), 145'(0));
        tick();
        chk("t1_rsp_v",    145'(bus.h_rsp_valid), 145'(1));
        chk("t1_rsp_data", 145'(bus.h_rsp_data), 145'(DMASK));
        chk("t1_rsp_err",  145'(bus.h_rsp_err), 145'(0));
        chk("t1_s_rsp_v",  145'(bus.s_rsp_valid), 145'(0));
        chk("t1_corr",     145'(bus.corr_cnt), 145'(0));
        tick();
        chk("t1_rsp_pulse", 145'(bus.h_rsp_valid), 145'(0));
        chk("t1_dec_en_off", 145'(bus.dec_en), 145'(0));

        // starvation: host wins 8 cycles, scrubber the 9th, host again
        bus.h_req = 1'b1; bus.h_code = mk(3'b000, 128'h11);
        bus.s_req = 1'b1; bus.s_code = mk(3'b000, 128'h22);
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_h_gnt_%0d", i), 145'({bus.h_gnt, bus.s_gnt}), 145'(2'b10));
            tick();
        end
        chk("t2_s_prio_gnt", 145'({bus.h_gnt, bus.s_gnt}), 145'(2'b01));
        tick();
        chk("t2_h_regain",  145'({bus.h_gnt, bus.s_gnt}), 145'(2'b10));
        chk("t2_s_issued",  bus.dec_code, mk(3'b000, 128'h22));
        bus.h_req = 1'b0; bus.s_req = 1'b0;
        repeat (4) tick();
        chk("t2_proto", 145'(bus.proto_err), 145'(0));

        // four back-to-back words, alternating owners: corr, fatal, detec, clean
        ca = mk(3'b001, 128'hA0A0);
        cb = mk(3'b100, 128'hB1B1);
        cc = mk(3'b010, 128'hC2C2);
        cd = mk(3'b000, 128'hD3D3);
        bus.h_req = 1'b1; bus.h_code = ca;
        #1;
        chk("t3_g0", 145'({bus.h_gnt, bus.s_gnt}), 145'(2'b10));
        tick(); bus.h_req = 1'b0; bus.s_req = 1'b1; bus.s_code = cb;
        #1;
        chk("t3_g1", 145'({bus.h_gnt, bus.s_gnt}), 145'(2'b01));
        tick(); bus.s_req = 1'b0; bus.h_req = 1'b1; bus.h_code = cc;
        tick(); bus.h_req = 1'b0; bus.s_req = 1'b1; bus.s_code = cd;
        chk("t3_r0_v",    145'(bus.h_rsp_valid), 145'(1));
        chk("t3_r0_data", 145'(bus.h_rsp_data), 145'(ca[127:0] ^ DMASK));
        chk("t3_r0_err",  145'(bus.h_rsp_err), 145'(2'b01));
        tick(); bus.s_req = 1'b0;
        chk("t3_r1_v",    145'({bus.h_rsp_valid, bus.s_rsp_valid}), 145'(2'b01));
        chk("t3_r1_data", 145'(bus.s_rsp_data), 145'(cb[127:0] ^ DMASK));
        chk("t3_r1_err",  145'(bus.s_rsp_err), 145'(2'b11));
        tick();
        chk("t3_r2_v",    145'({bus.h_rsp_valid, bus.s_rsp_valid}), 145'(2'b10));
        chk("t3_r2_data", 145'(bus.h_rsp_data), 145'(cc[127:0] ^ DMASK));
        chk("t3_r2_err",  145'(bus.h_rsp_err), 145'(2'b10));
        tick();
        chk("t3_r3_v",    145'({bus.h_rsp_valid, bus.s_rsp_valid}), 145'(2'b01));
        chk("t3_r3_data", 145'(bus.s_rsp_data), 145'(cd[127:0] ^ DMASK));
        chk("t3_r3_err",  145'(bus.s_rsp_err), 145'(2'b00));
        chk("t3_corr",    145'(bus.corr_cnt), 145'(CE ? 1 : 0));
        chk("t3_fatal",   145'(bus.fatal_cnt), 145'(CE ? 2 : 0));

        // clear, then saturate corr_cnt at 3 with five corrected words
        tick(); bus.cnt_clr = 1'b1;
        tick(); bus.cnt_clr = 1'b0;
        chk("t4_clr_corr",  145'(bus.corr_cnt), 145'(0));
        chk("t4_clr_fatal", 145'(bus.fatal_cnt), 145'(0));
        bus.h_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.h_code = mk(3'b001, 128'(i + 1));
            tick();
        end
        bus.h_req = 1'b0;
        repeat (4) tick();
        chk("t4_sat_corr",  145'(bus.corr_cnt), 145'(CE ? 3 : 0));
        chk("t4_sat_fatal", 145'(bus.fatal_cnt), 145'(0));
        // sixth corrected word with cnt_clr on its counting cycle
        bus.h_req = 1'b1; bus.h_code = mk(3'b001, 128'h66);
        tick(); bus.h_req = 1'b0;
        tick(); bus.cnt_clr = 1'b1;
        tick(); bus.cnt_clr = 1'b0;
        chk("t4_6_rsp_v",   145'(bus.h_rsp_valid), 145'(1));
        chk("t4_6_rsp_err", 145'(bus.h_rsp_err), 145'(2'b01));
        chk("t4_6_data",    145'(bus.h_rsp_data), 145'(128'h66 ^ DMASK));
        chk("t4_clr_wins",  145'(bus.corr_cnt), 145'(0));

        // stray dec_valid with empty pipeline
        tick(); inj = 1'b1;
        tick(); inj = 1'b0;
        tick();
        chk("t5_proto_set", 145'(bus.proto_err), 145'(1));
        chk("t5_no_rsp",    145'({bus.h_rsp_valid, bus.s_rsp_valid}), 145'(0));
        repeat (3) tick();
        chk("t5_proto_sticky", 145'(bus.proto_err), 145'(1));

        // reset with two words in flight
        bus.h_req = 1'b1; bus.h_code = mk(3'b000, 128'h77);
        tick(); bus.h_code = mk(3'b000, 128'h88);
        tick(); bus.h_req = 1'b0; reset = 1'b1;
        tick(); reset = 1'b0;
        chk("t6_rst_proto0", 145'(bus.proto_err), 145'(0));
        chk("t6_rst_rsp0",   145'({bus.h_rsp_valid, bus.s_rsp_valid}), 145'(0));
        tick();
        chk("t6_rst_rsp1",   145'({bus.h_rsp_valid, bus.s_rsp_valid}), 145'(0));
        chk("t6_rst_proto1", 145'(bus.proto_err), 145'(0));
        tick();
        chk("t6_rst_rsp2",   145'({bus.h_rsp_valid, bus.s_rsp_valid}), 145'(0));
        chk("t6_rst_proto2", 145'(bus.proto_err), 145'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
